ccip_c0_read_arbiter: RTL

- Shares the CCI-P channel-0 (read) request path between N user-side read clients inside the model wrapper, in the user clock domain.
- Round-robin arbitration; issues at most one read per cycle, respecting c0 almost-full backpressure and a per-client outstanding-read cap.
- Encodes the client ID into mdata and steers each read response back to its owning client.

---
 rtl/ccip_c0_read_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ccip_c0_read_arbiter.sv
// rtl/ccip_c0_read_arbiter.sv - round-robin CCI-P c0 read arbiter with per-client outstanding caps
// Tags each read with its client id in mdata and routes responses back by that id.
module ccip_c0_read_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int TAG_W     = 8,
  parameter int MAX_OUT   = 32,
  parameter int ADDR_W    = 42
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [N_CLIENTS-1:0]          req_valid,
  input  logic [N_CLIENTS*ADDR_W-1:0]   req_addr,
  input  logic [N_CLIENTS*TAG_W-1:0]    req_tag,
  output logic [N_CLIENTS-1:0]          req_ready,
  output logic                          tx_c0_valid,
  output logic [ADDR_W-1:0]             tx_c0_addr,
  output logic [15:0]                   tx_c0_mdata,
  input  logic                          c0_alm_full,
  input  logic                          rx_c0_valid,
  input  logic [15:0]                   rx_c0_mdata,
  input  logic [511:0]                  rx_c0_data,
  output logic [N_CLIENTS-1:0]          rsp_valid,
  output logic [TAG_W-1:0]              rsp_tag,
  output logic [511:0]                  rsp_data,
  output logic                          err_sticky
);

  localparam int CID_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CID_W-1:0] LAST_ID = CID_W'(N_CLIENTS - 1);

  logic [CID_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q [N_CLIENTS];
  logic [CNT_W-1:0]     cnt_d [N_CLIENTS];
  logic                 tx_valid_q, tx_valid_d;
  logic [ADDR_W-1:0]    tx_addr_q, tx_addr_d;
  logic [15:0]          tx_mdata_q, tx_mdata_d;
  logic [N_CLIENTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
  logic [511:0]         rsp_data_q, rsp_data_d;
  logic                 err_q, err_d;

  logic [N_CLIENTS-1:0] elig;
  logic [N_CLIENTS-1:0] grant_oh;
  logic                 grant_any;
  logic [CID_W-1:0]     grant_id;
  logic [CID_W-1:0]     cand_id;
  logic [CID_W-1:0]     rx_cid;
  logic [N_CLIENTS-1:0] rsp_hit;
  logic                 rsp_ok;

  // Round-robin search starting at rr_q, first eligible client wins.
  always_comb begin
    grant_oh  = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    cand_id   = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < MAX_CNT) && !c0_alm_full;
    end
    for (int k = 0; k < N_CLIENTS; k++) begin
      cand_id = CID_W'((int'(rr_q) + k) % N_CLIENTS);
      if (!grant_any && elig[cand_id]) begin
        grant_any = 1'b1;
        grant_id  = cand_id;
      end
    end
    if (grant_any) grant_oh[grant_id] = 1'b1;
  end

  assign req_ready = grant_oh & {N_CLIENTS{RST_N}};

  // A response only counts if its owner actually has a read in flight.
  always_comb begin
    rx_cid = rx_c0_mdata[TAG_W +: CID_W];
    for (int i = 0; i < N_CLIENTS; i++) begin
      rsp_hit[i] = rx_c0_valid && (rx_cid == CID_W'(i)) && (cnt_q[i] != '0);
    end
    rsp_ok = |rsp_hit;
  end

  always_comb begin
    rr_d        = rr_q;
    tx_valid_d  = grant_any;
    tx_addr_d   = tx_addr_q;
    tx_mdata_d  = tx_mdata_q;
    rsp_valid_d = rsp_hit;
    rsp_tag_d   = rsp_tag_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q | (rx_c0_valid && !rsp_ok);
    if (grant_any) begin
      rr_d       = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
      tx_addr_d  = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
      tx_mdata_d = 16'({grant_id, req_tag[int'(grant_id)*TAG_W +: TAG_W]});
    end
    if (rsp_ok) begin
      rsp_tag_d  = rx_c0_mdata[TAG_W-1:0];
      rsp_data_d = rx_c0_data;
    end
    for (int i = 0; i < N_CLIENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant_oh[i] && !rsp_hit[i])      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!grant_oh[i] && rsp_hit[i]) cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_q        <= '0;
      tx_valid_q  <= 1'b0;
      tx_addr_q   <= '0;
      tx_mdata_q  <= '0;
      rsp_valid_q <= '0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < N_CLIENTS; i++) cnt_q[i] <= '0;
    end else begin
      rr_q        <= rr_d;
      tx_valid_q  <= tx_valid_d;
      tx_addr_q   <= tx_addr_d;
      tx_mdata_q  <= tx_mdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      for (int i = 0; i < N_CLIENTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign tx_c0_valid = tx_valid_q;
  assign tx_c0_addr  = tx_addr_q;
  assign tx_c0_mdata = tx_mdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_data    = rsp_data_q;
  assign err_sticky  = err_q;

endmodule
